// File: rtl/pe_pkg.sv
// Shared types for the processing-element blocks: operating modes and the
// accumulator control states.
package pe_pkg;

  // Operating mode; only LOG adds the offset operand into the sum.
  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } mode_e;

  // Accumulator control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Three-operand signed saturating adder. The sum is formed two bits wider
// than the operands so no intermediate wrap can hide an overflow, then it
// is clamped back into the ACC_BW signed range.
module sat_add #(
  parameter int ACC_BW = 32
) (
  input  logic signed [ACC_BW-1:0] a,
  input  logic signed [ACC_BW-1:0] b,
  input  logic signed [ACC_BW-1:0] c,
  output logic signed [ACC_BW-1:0] sum,
  output logic                     ovf
);

  logic signed [ACC_BW+1:0] wide;
  logic        [2:0]        top;

  assign wide = (ACC_BW+2)'(a) + (ACC_BW+2)'(b) + (ACC_BW+2)'(c);
  assign top  = wide[ACC_BW+1:ACC_BW-1];

  // The wide sum fits in ACC_BW bits only when its three top bits agree;
  // otherwise clamp toward the sign of the wide result.
  always_comb begin
    ovf = !((top == 3'b000) || (top == 3'b111));
    sum = wide[ACC_BW-1:0];
    if (ovf) begin
      if (wide[ACC_BW+1]) begin
        sum = {1'b1, {(ACC_BW-1){1'b0}}};
      end else begin
        sum = {1'b0, {(ACC_BW-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/offset_acc.sv
// Signed term accumulator with optional per-term offset (LOG mode) and
// sticky saturation. A start latches mode and length, terms are accepted
// through a valid/ready handshake, and the final sum is presented until
// the consumer takes it. A new start may be taken in the same cycle the
// previous result is consumed.
module offset_acc
  import pe_pkg::*;
#(
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int CNT_BW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        gemm_uno,
  input  logic              start,
  input  logic [CNT_BW-1:0] len_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_BW-1:0] prod_i,
  input  logic [ACC_BW-1:0] offset_i,
  output logic [ACC_BW-1:0] acc_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_o,
  output logic              busy_o
);

  state_e              state;
  state_e              state_next;
  mode_e               mode;
  logic [CNT_BW-1:0]   remaining;
  logic [ACC_BW-1:0]   acc;
  logic                sat;

  logic                start_accept;
  logic                term_accept;
  logic                last_term;
  logic signed [ACC_BW-1:0] prod_ext;
  logic signed [ACC_BW-1:0] offset_sel;
  logic signed [ACC_BW-1:0] sum;
  logic                sum_ovf;

  assign start_accept = start && ((state == IDLE) || ((state == DONE) && out_ready));
  assign term_accept  = (state == ACC) && in_valid;
  assign last_term    = (remaining == CNT_BW'(1));

  assign prod_ext   = ACC_BW'($signed(prod_i));
  assign offset_sel = (mode == LOG) ? $signed(offset_i) : '0;

  sat_add #(
    .ACC_BW(ACC_BW)
  ) u_sat_add (
    .a  ($signed(acc)),
    .b  (prod_ext),
    .c  (offset_sel),
    .sum(sum),
    .ovf(sum_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; a zero-length start goes straight
  // to DONE so the consumer still sees exactly one (zero) result.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy_o     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len_i != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_term) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (start) begin
            state_next = (len_i != '0) ? ACC : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: clear on an accepted start, fold in each accepted term, and
  // hold everything otherwise so the DONE result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sat       <= 1'b0;
      remaining <= '0;
      mode      <= GEMM;
    end else if (start_accept) begin
      acc       <= '0;
      sat       <= 1'b0;
      remaining <= len_i;
      mode      <= mode_e'(gemm_uno);
    end else if (term_accept) begin
      acc       <= sum;
      sat       <= sat | sum_ovf;
      remaining <= remaining - CNT_BW'(1);
    end
  end

  assign acc_o = acc;
  assign sat_o = sat;

endmodule

// File: tb/tb_offset_acc.sv
// Directed bench for offset_acc: handshake timing, offset gating by mode,
// saturation in both directions, zero length, back-to-back restart,
// mid-run reset and a maximum-length run.
module tb_offset_acc;
  import pe_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  gemm_uno;
  logic        start;
  logic [7:0]  len_i;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] prod_i;
  logic [31:0] offset_i;
  logic [31:0] acc_o;
  logic        out_valid;
  logic        out_ready;
  logic        sat_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  offset_acc dut (
    .clk      (clk),
    .rst      (rst),
    .gemm_uno (gemm_uno),
    .start    (start),
    .len_i    (len_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .prod_i   (prod_i),
    .offset_i (offset_i),
    .acc_o    (acc_o),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_o    (sat_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and return at the next
  // falling edge, after the rising edge has consumed them.
  task automatic applyStimulus(input logic st, input logic [7:0] len, input logic [1:0] mode,
                               input logic iv, input logic [15:0] prod, input logic [31:0] off,
                               input logic ordy);
    start     = st;
    len_i     = len;
    gemm_uno  = mode;
    in_valid  = iv;
    prod_i    = prod;
    offset_i  = off;
    out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; len_i = '0; gemm_uno = '0; in_valid = 1'b0;
    prod_i = '0; offset_i = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_acc", acc_o, 32'h0);
    checkOutput("rst_sat", {31'b0, sat_o}, 32'h0);
    checkOutput("rst_ovalid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_iready", {31'b0, in_ready}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'h0);
    rst = 1'b0;

    // gemm, len 3, offsets ignored; a stall cycle carries an ignored start
    applyStimulus(1, 3, GEMM, 0, 16'h0, 32'h0, 0);
    checkOutput("g_iready", {31'b0, in_ready}, 32'h1);
    checkOutput("g_busy", {31'b0, busy_o}, 32'h1);
    applyStimulus(0, 0, GEMM, 1, 16'd5, 32'd100, 0);
    checkOutput("g_run1", acc_o, 32'd5);
    applyStimulus(1, 7, LOG, 0, 16'h0, 32'h0, 0);
    checkOutput("g_stall", acc_o, 32'd5);
    applyStimulus(0, 0, GEMM, 1, 16'hFFFE, 32'd100, 0);
    checkOutput("g_run2", acc_o, 32'd3);
    checkOutput("g_ovalid_early", {31'b0, out_valid}, 32'h0);
    applyStimulus(0, 0, GEMM, 1, 16'd7, 32'd100, 0);
    checkOutput("g_ovalid", {31'b0, out_valid}, 32'h1);
    checkOutput("g_acc", acc_o, 32'd10);
    checkOutput("g_sat", {31'b0, sat_o}, 32'h0);
    checkOutput("g_iready_done", {31'b0, in_ready}, 32'h0);
    applyStimulus(1, 5, GEMM, 1, 16'd99, 32'h0, 0);
    checkOutput("g_hold_ovalid", {31'b0, out_valid}, 32'h1);
    checkOutput("g_hold_acc", acc_o, 32'd10);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);
    checkOutput("g_release_ovalid", {31'b0, out_valid}, 32'h0);
    checkOutput("g_release_busy", {31'b0, busy_o}, 32'h0);

    // log mode adds the offset
    applyStimulus(1, 2, LOG, 0, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, GEMM, 1, 16'd1, 32'h1000, 0);
    applyStimulus(0, 0, GEMM, 1, 16'd1, 32'h1000, 0);
    checkOutput("l_ovalid", {31'b0, out_valid}, 32'h1);
    checkOutput("l_acc", acc_o, 32'h2002);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);

    // positive clamp
    applyStimulus(1, 2, LOG, 0, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, GEMM, 1, 16'h0, 32'h7FFFFFF0, 0);
    checkOutput("sp_pre", acc_o, 32'h7FFFFFF0);
    checkOutput("sp_pre_sat", {31'b0, sat_o}, 32'h0);
    applyStimulus(0, 0, GEMM, 1, 16'h7FFF, 32'h0, 0);
    checkOutput("sp_acc", acc_o, 32'h7FFFFFFF);
    checkOutput("sp_sat", {31'b0, sat_o}, 32'h1);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);

    // negative clamp, sticky flag survives a later in-range term
    applyStimulus(1, 3, LOG, 0, 16'h0, 32'h0, 0);
    checkOutput("sn_sat_clear", {31'b0, sat_o}, 32'h0);
    applyStimulus(0, 0, GEMM, 1, 16'h0, 32'h80000010, 0);
    applyStimulus(0, 0, GEMM, 1, 16'hFFE0, 32'h0, 0);
    checkOutput("sn_acc", acc_o, 32'h80000000);
    checkOutput("sn_sat", {31'b0, sat_o}, 32'h1);
    applyStimulus(0, 0, GEMM, 1, 16'd5, 32'h0, 0);
    checkOutput("sn_final", acc_o, 32'h80000005);
    checkOutput("sn_sticky", {31'b0, sat_o}, 32'h1);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);

    // exp mode: negative product sign-extends, offset ignored
    applyStimulus(1, 1, EXP, 0, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, GEMM, 1, 16'hFFFD, 32'd50, 0);
    checkOutput("e_acc", acc_o, 32'hFFFFFFFD);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);

    // zero length
    applyStimulus(1, 0, GEMM, 1, 16'd9, 32'h0, 0);
    checkOutput("z_ovalid", {31'b0, out_valid}, 32'h1);
    checkOutput("z_acc", acc_o, 32'h0);
    checkOutput("z_iready", {31'b0, in_ready}, 32'h0);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);

    // back-to-back restart from DONE
    applyStimulus(1, 1, GEMM, 0, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, GEMM, 1, 16'd9, 32'h0, 0);
    checkOutput("b_first", acc_o, 32'd9);
    applyStimulus(1, 1, GEMM, 0, 16'h0, 32'h0, 1);
    checkOutput("b_iready", {31'b0, in_ready}, 32'h1);
    checkOutput("b_ovalid", {31'b0, out_valid}, 32'h0);
    checkOutput("b_cleared", acc_o, 32'h0);
    applyStimulus(0, 0, GEMM, 1, 16'd4, 32'h0, 0);
    checkOutput("b_second_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("b_second", acc_o, 32'd4);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);

    // reset after 2 of 4 terms
    applyStimulus(1, 4, GEMM, 0, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, GEMM, 1, 16'd3, 32'h0, 0);
    applyStimulus(0, 0, GEMM, 1, 16'd3, 32'h0, 0);
    checkOutput("r_partial", acc_o, 32'd6);
    rst = 1'b1;
    applyStimulus(0, 0, GEMM, 1, 16'd3, 32'h0, 0);
    rst = 1'b0;
    checkOutput("r_acc", acc_o, 32'h0);
    checkOutput("r_iready", {31'b0, in_ready}, 32'h0);
    checkOutput("r_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("r_ovalid", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, GEMM, 1, 16'd3, 32'h0, 0);
      checkOutput("r_after_ovalid", {31'b0, out_valid}, 32'h0);
      checkOutput("r_after_acc", acc_o, 32'h0);
    end

    // maximum length: 255 terms of 1
    applyStimulus(1, 8'd255, GEMM, 0, 16'h0, 32'h0, 0);
    for (int i = 0; i < 254; i++) begin
      applyStimulus(0, 0, GEMM, 1, 16'd1, 32'h0, 0);
    end
    checkOutput("m_not_done", {31'b0, out_valid}, 32'h0);
    checkOutput("m_partial", acc_o, 32'd254);
    applyStimulus(0, 0, GEMM, 1, 16'd1, 32'h0, 0);
    checkOutput("m_done", {31'b0, out_valid}, 32'h1);
    checkOutput("m_acc", acc_o, 32'd255);
    applyStimulus(0, 0, GEMM, 0, 16'h0, 32'h0, 1);
    checkOutput("m_idle", {31'b0, busy_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
